// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared types and defaults for the MSB-first serial-to-parallel receiver
package sipo_pkg;

    localparam int SIPO_DW_DEFAULT = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } sipo_state_t;

endpackage

// File: rtl/sipo_bit_cnt.sv
// rtl/sipo_bit_cnt.sv - frame bit counter with last-bit flag
module sipo_bit_cnt
    import sipo_pkg::*;
#(
    parameter int DW = SIPO_DW_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_last
);

    localparam int CW = $clog2(DW) + 1;

    logic [CW-1:0] r_cnt;

    // Count is the number of bits already held in the shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CW'(1);
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_last = (r_cnt == CW'(DW - 1));

endmodule

// File: rtl/sipo_msb_rx.sv
// rtl/sipo_msb_rx.sv - MSB-first serial receiver with one-word output holding register
module sipo_msb_rx
    import sipo_pkg::*;
#(
    parameter int DW = SIPO_DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enb,
    input  logic          start,
    input  logic          sin,
    input  logic          clr_ovf,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    input  logic          dout_rdy,
    output logic          busy,
    output logic          ovf
);

    sipo_state_t   r_state;
    sipo_state_t   w_next;
    logic [DW-1:0] r_sreg;
    logic [DW-1:0] r_dout;
    logic          r_vld;
    logic          r_ovf;

    logic          w_load;
    logic          w_step;
    logic          w_last;
    logic          w_done;
    logic          w_ovr;
    logic [DW-1:0] w_word;

    // A qualified start always (re)begins a frame, in either state.
    assign w_load = enb && start;
    assign w_step = (r_state == SHIFT) && enb && !start;
    assign w_done = w_step && w_last;
    assign w_word = {r_sreg[DW-2:0], sin};
    assign w_ovr  = w_done && r_vld && !dout_rdy;

    sipo_bit_cnt #(
        .DW(DW)
    ) u_bit_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_inc  (w_step && !w_last),
        .i_clr  (w_done),
        .o_last (w_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_load) w_next = SHIFT;
            SHIFT:   if (w_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sreg <= '0;
        end else if (w_load) begin
            r_sreg <= {{(DW-1){1'b0}}, sin};
        end else if (w_step) begin
            r_sreg <= w_word;
        end
    end

    // Holding register: a completed word replaces an accepted one on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dout <= '0;
            r_vld  <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_done && (!r_vld || dout_rdy)) begin
                r_dout <= w_word;
                r_vld  <= 1'b1;
            end else if (r_vld && dout_rdy) begin
                r_vld  <= 1'b0;
            end
            if (w_ovr) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign dout     = r_dout;
    assign dout_vld = r_vld;
    assign ovf      = r_ovf;
    assign busy     = (r_state == SHIFT);

endmodule

// File: tb/tb_sipo_msb_rx.sv
// tb/tb_sipo_msb_rx.sv - scoreboard bench for sipo_msb_rx
module tb_sipo_msb_rx;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enb, start, sin, clr_ovf, dout_rdy;
    logic [DW-1:0] dout;
    logic          dout_vld, busy, ovf;

    int total = 0;
    int bad   = 0;

    int            m_bits[$];
    bit            m_frame, m_vld, m_ovf;
    logic [DW-1:0] m_dout;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    sipo_msb_rx #(.DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .enb      (enb),
        .start    (start),
        .sin      (sin),
        .clr_ovf  (clr_ovf),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_rdy (dout_rdy),
        .busy     (busy),
        .ovf      (ovf)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        exp_q.delete();
        m_frame = 0;
        m_vld   = 0;
        m_ovf   = 0;
        m_dout  = '0;
    endtask

    // One clock: check visible state, drive inputs, advance the frame-level model.
    task automatic cyc(input bit e, input bit s, input bit d, input bit r, input bit c);
        bit            done;
        logic [DW-1:0] word;
        chk("busy", busy, m_frame);
        chk("dout_vld", dout_vld, m_vld);
        chk("ovf", ovf, m_ovf);
        if (m_vld) chk("dout_hold", dout, m_dout);
        enb = e; start = s; sin = d; dout_rdy = r; clr_ovf = c;
        done = 0;
        word = '0;
        if (e) begin
            if (s) begin
                m_bits = {int'(d)};
                m_frame = 1;
            end else if (m_frame) begin
                m_bits.push_back(int'(d));
                if (m_bits.size() == DW) begin
                    foreach (m_bits[k]) word = (word << 1) | DW'(m_bits[k]);
                    done = 1;
                    m_frame = 0;
                end
            end
        end
        if (done && m_vld && !r) begin
            m_ovf = 1;
        end else begin
            if (c) m_ovf = 0;
            if (done) begin
                m_vld  = 1;
                m_dout = word;
                exp_q.push_back(word);
            end else if (m_vld && r) begin
                m_vld = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [DW-1:0] w, input int gap, input bit r, input bit r_last);
        for (int i = DW - 1; i >= 0; i--) begin
            cyc(1, i == DW - 1, w[i], (i == 0) ? r_last : r, 0);
            for (int g = 0; g < gap; g++) cyc(0, 0, 1'($urandom), r, 0);
        end
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, r, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        chk("rst_dout", dout, 0);
        chk("rst_vld", dout_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted word must be the next one the model delivered.
    always @(negedge clk) begin
        if (rst === 1'b1 && dout_vld === 1'b1 && dout_rdy === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", dout, 32'hFFFF_FFFF);
            end else begin
                chk("accepted_word", dout, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        enb = 0; start = 0; sin = 0; clr_ovf = 0; dout_rdy = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("por_dout", dout, 0);
        chk("por_vld", dout_vld, 0);
        chk("por_busy", busy, 0);
        chk("por_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // basic frame, then gapped strobe
        frame(4'hB, 0, 1, 1);
        idle(3, 1);
        frame(4'hB, 3, 1, 1);
        idle(3, 1);

        // overrun and clear
        frame(4'hA, 0, 0, 0);
        frame(4'h5, 1, 0, 0);
        idle(2, 0);
        chk("ovr_dout", dout, 4'hA);
        chk("ovr_flag", ovf, 1);
        cyc(0, 0, 0, 0, 1);
        idle(1, 0);
        chk("ovf_cleared", ovf, 0);
        idle(2, 1);

        // completion coinciding with acceptance
        frame(4'h3, 0, 0, 0);
        frame(4'hC, 0, 0, 1);
        chk("b2b_dout", dout, 4'hC);
        chk("b2b_vld", dout_vld, 1);
        chk("b2b_ovf", ovf, 0);
        idle(2, 1);

        // resynchronisation discards the partial word
        cyc(1, 1, 1, 1, 0);
        cyc(1, 0, 1, 1, 0);
        frame(4'h6, 0, 1, 1);
        idle(2, 1);

        // reset mid-frame
        cyc(1, 1, 1, 1, 0);
        cyc(1, 0, 0, 1, 0);
        do_reset();
        for (int i = 0; i < 6; i++) cyc(1, 0, 1'($urandom), 1, 0);
        frame(4'h9, 0, 1, 1);
        idle(2, 1);

        // set wins over simultaneous clear
        frame(4'h7, 0, 0, 0);
        for (int i = DW - 1; i >= 0; i--) cyc(1, i == DW - 1, 1'(i), 0, i == 0);
        idle(1, 0);
        cyc(0, 0, 0, 0, 1);
        idle(2, 1);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, 1'($urandom),
                1'($urandom), $urandom_range(0, 9) == 0);
        end

        idle(4, 1);
        chk("drain_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sipo_msb_rx.md
SIPO_MSB_RX -- requirements
Module: sipo_msb_rx

Interface
REQ-001 Parameter: DW, default 4, word width in bits; SHALL be >= 2.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 enb  input  1  bit strobe; sin and start are sampled only on cycles with enb=1.
REQ-005 start  input  1  frame marker; qualified by enb, flags the current sin as the first (MSB) bit of a word.
REQ-006 sin  input  1  serial data, MSB first.
REQ-007 clr_ovf  input  1  synchronous clear of ovf.
REQ-008 dout  output  DW  assembled parallel word, held stable while dout_vld=1.
REQ-009 dout_vld  output  1  dout holds an unconsumed word.
REQ-010 dout_rdy  input  1  consumer accepts dout when dout_vld=1 and dout_rdy=1.
REQ-011 busy  output  1  frame in progress, i.e. state SHIFT.
REQ-012 ovf  output  1  sticky overrun flag.

Function
REQ-013 FSM states SHALL be exactly IDLE and SHIFT; busy=1 only in SHIFT.
REQ-014 IDLE with enb=1, start=1: shift register <= {zeros, sin}; bit count <= 1; go to SHIFT.
REQ-015 IDLE with enb=0 or start=0: hold state; sin ignored.
REQ-016 SHIFT with enb=1, start=0: shift register <= {sreg[DW-2:0], sin}; bit count increments.
REQ-017 SHIFT with enb=1, start=1: resynchronise; behave as REQ-014; the partial word is discarded without flagging.
REQ-018 SHIFT with enb=0: hold all state.
REQ-019 Completion: the enb=1, start=0 cycle that samples bit DW-1 returns the FSM to IDLE and delivers {sreg[DW-2:0], sin} to the output stage on the same edge.
REQ-020 Latency: dout and dout_vld update on the edge that samples the last bit, so they are visible 1 cycle after that enb.
REQ-021 The output stage is a one-word holding register separate from the shift register, so reception of the next frame continues while a word waits.
REQ-022 Handshake: dout_vld clears on the edge after a cycle with dout_vld=1 and dout_rdy=1, unless REQ-023 applies.
REQ-023 Completion in the same cycle as acceptance: load the new word and keep dout_vld=1; no overrun.
REQ-024 Completion while dout_vld=1 and dout_rdy=0: drop the new word; dout unchanged; ovf <= 1.
REQ-025 ovf stays 1 until a cycle with clr_ovf=1 and no simultaneous overrun; if both occur in the same cycle, the set wins.
REQ-026 dout_rdy with dout_vld=0 has no effect.
REQ-027 Bit count width SHALL be $clog2(DW)+1; the count never exceeds DW-1.

Reset
REQ-028 rst=0 asynchronously forces: state IDLE, shift register 0, bit count 0, dout 0, dout_vld 0, ovf 0, busy 0.
REQ-029 Reset mid-frame discards the partial word; the first frame after release requires a new start.

Structure
REQ-030 Shared package sipo_pkg SHALL hold the state enum type (IDLE, SHIFT) and the default DW constant.
REQ-031 One sub-module, sipo_bit_cnt, SHALL provide the bit counter: load-1, increment on enb, and a last-bit flag. The FSM, shift register and output stage stay in sipo_msb_rx.

Verification
REQ-032 Basic frame (DW=4): start on bit 1, sin=1,0,1,1 on 4 consecutive enb cycles, dout_rdy=1 -> dout=4'hB, dout_vld=1 for 1 cycle, starting 1 cycle after the 4th bit.
REQ-033 Gapped strobe: same frame 1011 with enb=0 for 3 cycles between every bit -> dout=4'hB, busy=1 throughout the frame; no early dout_vld.
REQ-034 Overrun: frame 4'hA received and held with dout_rdy=0; frame 4'h5 completes -> dout stays 4'hA, ovf=1; then clr_ovf=1 -> ovf=0.
REQ-035 Back-to-back: frame 4'h3 waiting; frame 4'hC completes in the same cycle as dout_rdy=1 -> dout=4'hC, dout_vld stays 1, ovf=0.
REQ-036 Resync: start, bits 1,1; then start with bits 0,1,1,0 -> dout=4'h6; the partial word is never output.
REQ-037 Reset mid-frame: rst=0 after 2 bits -> all outputs 0; bits without start are ignored; the next full frame 4'h9 -> dout=4'h9.
